// File: rtl/clk_div_bank_if.sv
// Divisor write port for clk_div_bank.
// Valid/ready transfer of a channel index and half-period.
interface clk_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_chan;
  logic [WIDTH-1:0] cfg_half;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_bank.sv
// Programmable multi-channel 50% clock divider bank with edge pulses.
// Define CLK_DIV_BANK_SYNC_EN to build the global sync realign logic.
module clk_div_bank #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int DEFAULT_FREQ = 1,
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  clk_div_bank_if.slave       cfg,
  output logic [CHANNELS-1:0] divided_clk,
  output logic [CHANNELS-1:0] divided_pulse
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] RST_H =
    WIDTH'(CLK_FREQ / DEFAULT_FREQ / 2);

  logic [WIDTH-1:0]    r_h [CHANNELS];
  logic [WIDTH-1:0]    r_s [CHANNELS];
  logic [WIDTH-1:0]    r_c [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] r_pulse;

  logic                w_ready;
  logic                w_sync;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_run;
  logic [CHANNELS-1:0] w_last;

`ifdef CLK_DIV_BANK_SYNC_EN
  assign w_sync = sync;
`else
  logic w_unused_sync;
  assign w_unused_sync = sync;
  assign w_sync = 1'b0;
`endif

  // Out-of-range channels never block, so such writes are dropped.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == CW'(i))
        w_ready = ~r_pend[i];
    end
  end

  assign cfg.cfg_ready = w_ready;

  always_comb begin
    w_wr   = '0;
    w_run  = '0;
    w_last = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr[i]   = cfg.cfg_valid && w_ready &&
                  (cfg.cfg_chan == CW'(i));
      w_run[i]  = enable[i] && (r_h[i] != '0);
      w_last[i] = (r_c[i] == r_h[i] - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_h[i] <= RST_H;
        r_s[i] <= '0;
        r_c[i] <= '0;
      end
      r_pend  <= '0;
      r_q     <= '0;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i] <= 1'b0;
        if (w_wr[i]) begin
          r_s[i]    <= cfg.cfg_half;
          r_pend[i] <= 1'b1;
        end
        if (w_sync) begin
          r_c[i] <= '0;
          r_q[i] <= 1'b0;
          if (r_pend[i]) begin
            r_h[i]    <= r_s[i];
            r_pend[i] <= 1'b0;
          end
        end else if (r_pend[i] && !w_run[i]) begin
          r_h[i]    <= r_s[i];
          r_pend[i] <= 1'b0;
          r_c[i]    <= '0;
          r_q[i]    <= 1'b0;
        end else if (w_run[i]) begin
          if (w_last[i]) begin
            r_c[i]     <= '0;
            r_q[i]     <= ~r_q[i];
            r_pulse[i] <= ~r_q[i];
            // High-to-low toggle is the only safe swap point.
            if (r_q[i] && r_pend[i]) begin
              r_h[i]    <= r_s[i];
              r_pend[i] <= 1'b0;
            end
          end else begin
            r_c[i] <= r_c[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  assign divided_clk   = r_q;
  assign divided_pulse = r_pulse;

endmodule
